// File: rtl/ovr_pkg.sv
// Shared types for the variable override cell and the sources that drive it.
package ovr_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        ASSIGNED = 2'd1,
        FORCED   = 2'd2,
        FORCED_A = 2'd3
    } ovr_mode_e;

    // Strobe bundle for drivers; field order follows control priority, then data priority.
    typedef struct packed {
        logic frc_en;
        logic rel_en;
        logic asg_en;
        logic dasg_en;
        logic dep_en;
        logic wr_en;
    } ovr_cmd_t;

endpackage

// File: rtl/var_override_cell.sv
// Storage cell for one overridable variable: resolves deposit/write and
// assign/deassign/force/release commands and presents the effective value.
module var_override_cell
    import ovr_pkg::*;
#(
    parameter int unsigned          WIDTH     = 4,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             dep_en,
    input  logic [WIDTH-1:0] dep_data,
    input  logic             asg_en,
    input  logic [WIDTH-1:0] asg_data,
    input  logic             dasg_en,
    input  logic             frc_en,
    input  logic [WIDTH-1:0] frc_data,
    input  logic             rel_en,
    output logic [WIDTH-1:0] q,
    output logic [1:0]       mode,
    output logic             blocked,
    output logic             nop
);

    ovr_mode_e        state, state_nx;
    logic [WIDTH-1:0] q_nx, asg_val, asg_val_nx;
    logic             blocked_nx, nop_nx;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nx   = state;
        q_nx       = q;
        asg_val_nx = asg_val;
        blocked_nx = 1'b0;
        nop_nx     = 1'b0;

        // Control commands: only the highest-priority strobe acts.
        if (frc_en) begin
            q_nx = frc_data;
            case (state)
                NORMAL:   state_nx = FORCED;
                ASSIGNED: state_nx = FORCED_A;
                default:  state_nx = state;
            endcase
        end else if (rel_en) begin
            case (state)
                FORCED:   state_nx = NORMAL;
                FORCED_A: begin
                    state_nx = ASSIGNED;
                    q_nx     = asg_val;
                end
                default:  nop_nx = 1'b1;
            endcase
        end else if (asg_en) begin
            asg_val_nx = asg_data;
            if (state == NORMAL || state == ASSIGNED) begin
                state_nx = ASSIGNED;
                q_nx     = asg_data;
            end else begin
                state_nx = FORCED_A;
            end
        end else if (dasg_en) begin
            case (state)
                ASSIGNED: state_nx = NORMAL;
                FORCED_A: begin
                    state_nx   = FORCED;
                    asg_val_nx = '0;
                end
                default:  nop_nx = 1'b1;
            endcase
        end

        // Data commands see the post-control mode and override any control value only in NORMAL.
        if (dep_en || wr_en) begin
            if (state_nx == NORMAL) begin
                q_nx = dep_en ? dep_data : wr_data;
            end else begin
                blocked_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= NORMAL;
            q       <= RESET_VAL;
            asg_val <= '0;
            blocked <= 1'b0;
            nop     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state   <= state_nx;
            q       <= q_nx;
            asg_val <= asg_val_nx;
            blocked <= blocked_nx;
            nop     <= nop_nx;
        end
    end

    assign mode = state;

endmodule
